pll_reconfig_seq: RTL and testbench

//  Sequences runtime retuning of the fractional system PLL (100.663284/3.579138 MHz outputs).

---
 rtl/pll_reconfig_seq.sv | 216 +++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// Runtime retuning sequencer for the fractional system PLL: programs the
// Avalon-MM reconfig port, polls status, waits for stable lock with retries.
module pll_reconfig_seq #(
  parameter int unsigned LOCK_TIMEOUT = 5000000,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RST_CYCLES   = 16
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic [31:0] cfg_k,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        lock_lost,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [22:0]   TIMEOUT_LAST = 23'(LOCK_TIMEOUT - 1);
  localparam logic [22:0]   RST_LAST     = 23'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_POLL, S_WAIT_LOCK, S_RESET_PLL, S_DONE, S_ERR
  } state_t;

  state_t        state, state_n;
  logic [2:0]    step, step_n, step_inc;
  logic [22:0]   timer, timer_n;
  logic [SW-1:0] stable, stable_n;
  logic [RW-1:0] retry, retry_n;
  logic          error_n, lock_lost_n, armed, armed_n;
  logic          write_n, read_n;
  logic [5:0]    addr_n, beat_addr;
  logic [31:0]   wdata_n, beat_data;
  logic          lock_meta, lock_sync;
  logic [17:0]   snap_n, snap_m, snap_c0, snap_c1;
  logic [31:0]   snap_k;
  logic          load;
  logic          rd_unused;

  assign rd_unused = ^mgmt_readdata[31:1];
  assign load      = (state == S_IDLE) && cfg_start;
  assign busy      = (state == S_WRITE) || (state == S_POLL) ||
                     (state == S_WAIT_LOCK) || (state == S_RESET_PLL);
  assign done      = (state == S_DONE);
  assign pll_rst   = (state == S_RESET_PLL);
  assign step_inc  = step + 3'd1;

  // Register beat following the current one; beat 0 (mode) is issued from IDLE.
  always_comb begin
    beat_addr = 6'h00;
    beat_data = 32'h0000_0001;
    case (step_inc)
      3'd1: begin beat_addr = 6'h03; beat_data = {14'b0, snap_n}; end
      3'd2: begin beat_addr = 6'h04; beat_data = {14'b0, snap_m}; end
      3'd3: begin beat_addr = 6'h05; beat_data = {9'b0, 5'd0, snap_c0}; end
      3'd4: begin beat_addr = 6'h05; beat_data = {9'b0, 5'd1, snap_c1}; end
      3'd5: begin beat_addr = 6'h07; beat_data = snap_k; end
      3'd6: begin beat_addr = 6'h02; beat_data = 32'h0; end
      default: ;
    endcase
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    timer_n     = (timer == '1) ? timer : timer + 23'd1;
    stable_n    = stable;
    retry_n     = retry;
    error_n     = error;
    lock_lost_n = lock_lost;
    armed_n     = armed;
    write_n     = mgmt_write;
    read_n      = mgmt_read;
    addr_n      = mgmt_address;
    wdata_n     = mgmt_writedata;
    unique case (state)
      S_IDLE: begin
        write_n = 1'b0;
        read_n  = 1'b0;
        if (cfg_start) begin
          error_n     = 1'b0;
          lock_lost_n = 1'b0;
          armed_n     = 1'b0;
          retry_n     = '0;
          step_n      = 3'd0;
          state_n     = S_WRITE;
          write_n     = 1'b1;
          addr_n      = 6'h00;
          wdata_n     = 32'h0000_0001;
        end else if (armed && !lock_sync) begin
          lock_lost_n = 1'b1;
        end
      end
      S_WRITE: begin
        if (!mgmt_waitrequest) begin
          if (step == 3'd6) begin
            write_n = 1'b0;
            read_n  = 1'b1;
            addr_n  = 6'h01;
            wdata_n = 32'h0;
            timer_n = '0;
            state_n = S_POLL;
          end else begin
            step_n  = step_inc;
            addr_n  = beat_addr;
            wdata_n = beat_data;
          end
        end
      end
      S_POLL: begin
        if (timer >= TIMEOUT_LAST) begin
          read_n  = 1'b0;
          error_n = 1'b1;
          state_n = S_ERR;
        end else if (!mgmt_waitrequest && mgmt_readdata[0]) begin
          read_n   = 1'b0;
          timer_n  = '0;
          stable_n = '0;
          state_n  = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        stable_n = lock_sync ? stable + SW'(1) : '0;
        if (lock_sync && stable == STABLE_LAST) begin
          state_n = S_DONE;
        end else if (timer >= TIMEOUT_LAST) begin
          if (retry < RETRY_MAX) begin
            retry_n = retry + RW'(1);
            timer_n = '0;
            state_n = S_RESET_PLL;
          end else begin
            error_n = 1'b1;
            state_n = S_ERR;
          end
        end
      end
      S_RESET_PLL: begin
        if (timer >= RST_LAST) begin
          timer_n  = '0;
          stable_n = '0;
          state_n  = S_WAIT_LOCK;
        end
      end
      S_DONE: begin
        armed_n = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state          <= S_IDLE;
      step           <= '0;
      timer          <= '0;
      stable         <= '0;
      retry          <= '0;
      error          <= 1'b0;
      lock_lost      <= 1'b0;
      armed          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      lock_meta      <= 1'b0;
      lock_sync      <= 1'b0;
      snap_n         <= '0;
      snap_m         <= '0;
      snap_c0        <= '0;
      snap_c1        <= '0;
      snap_k         <= '0;
    end else begin
      state          <= state_n;
      step           <= step_n;
      timer          <= timer_n;
      stable         <= stable_n;
      retry          <= retry_n;
      error          <= error_n;
      lock_lost      <= lock_lost_n;
      armed          <= armed_n;
      mgmt_write     <= write_n;
      mgmt_read      <= read_n;
      mgmt_address   <= addr_n;
      mgmt_writedata <= wdata_n;
      lock_meta      <= pll_locked;
      lock_sync      <= lock_meta;
      if (load) begin
        snap_n  <= cfg_n;
        snap_m  <= cfg_m;
        snap_c0 <= cfg_c0;
        snap_c1 <= cfg_c1;
        snap_k  <= cfg_k;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: bus sequence, stalls, lock filtering,
// retries/timeout, lock-loss detection and mid-sequence reset.
module tb_pll_reconfig_seq;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1;
  logic [31:0] cfg_k;
  logic        busy, done, error, lock_lost, pll_rst;
  logic        pll_locked = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = '0;
  logic        mgmt_waitrequest = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned t0, d0;
  int unsigned rst_cnt, pulses, done_cnt;
  logic        prev_rst;
  logic [5:0]  exp_addr [7];
  logic [31:0] exp_data [7];

  pll_reconfig_seq #(
    .LOCK_TIMEOUT(100),
    .LOCK_STABLE (16),
    .MAX_RETRY   (2),
    .RST_CYCLES  (16)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_c0          (cfg_c0),
    .cfg_c1          (cfg_c1),
    .cfg_k           (cfg_k),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .lock_lost       (lock_lost),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .mgmt_address    (mgmt_address),
    .mgmt_write      (mgmt_write),
    .mgmt_read       (mgmt_read),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest)
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic set_cfg(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                         input logic [17:0] c1, input logic [31:0] k);
    cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1; cfg_k = k;
  endtask

  task automatic load_exp1;
    exp_addr = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h05, 6'h07, 6'h02};
    exp_data = '{32'h1, 32'h202, 32'h20504, 32'h303, 32'h50101, 32'hA3D70A3D, 32'h0};
  endtask

  task automatic run_writes;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("w%0d_addr", i), mgmt_address, exp_addr[i]);
      check($sformatf("w%0d_data", i), mgmt_writedata, exp_data[i]);
      check($sformatf("w%0d_wr", i), mgmt_write, 1);
      check($sformatf("w%0d_rd", i), mgmt_read, 0);
      tick();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_lost"}, lock_lost, 0);
    check({tag, "_pllrst"}, pll_rst, 0);
    check({tag, "_addr"}, mgmt_address, 0);
    check({tag, "_wr"}, mgmt_write, 0);
    check({tag, "_rd"}, mgmt_read, 0);
    check({tag, "_wdata"}, mgmt_writedata, 0);
  endtask

  initial begin
    set_cfg('0, '0, '0, '0, '0);
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Zero-wait sequence, poll answers on 3rd read, lock from T+20
    set_cfg(18'h00202, 18'h20504, 18'h00303, 18'h10101, 32'hA3D70A3D);
    load_exp1();
    t0 = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    set_cfg('1, '1, '1, '1, '1);
    check("t1_busy", busy, 1);
    run_writes();
    check("t1_rd1", mgmt_read, 1);
    check("t1_rd1_addr", mgmt_address, 6'h01);
    tick();
    check("t1_rd2", mgmt_read, 1);
    tick();
    mgmt_readdata = 32'h1;
    check("t1_rd3", mgmt_read, 1);
    tick();
    mgmt_readdata = 32'h0;
    check("t1_rd_end", mgmt_read, 0);
    check("t1_busy_wait", busy, 1);
    while (cyc < t0 + 20) tick();
    pll_locked = 1'b1;
    while (cyc < t0 + 38) begin
      check("t1_no_early_done", done, 0);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_done_busy", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // Lock lost in IDLE after success
    d0 = cyc;
    pll_locked = 1'b0;
    check("t2_lost_d0", lock_lost, 0);
    tick();
    check("t2_lost_d1", lock_lost, 0);
    tick();
    check("t2_lost_d2", lock_lost, 0);
    tick();
    check("t2_lost_d3", lock_lost, 1);
    tick();
    check("t2_lost_sticky", lock_lost, 1);

    // Stall on W_M; start while busy ignored
    set_cfg(18'h00101, 18'h00A0A, 18'h20403, 18'h00202, 32'h00008000);
    t0 = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t3_lost_clr", lock_lost, 0);
    check("t3_busy", busy, 1);
    check("t3_mode_addr", mgmt_address, 6'h00);
    check("t3_mode_data", mgmt_writedata, 32'h1);
    tick();
    check("t3_n_addr", mgmt_address, 6'h03);
    check("t3_n_data", mgmt_writedata, 32'h101);
    tick();
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mgmt_waitrequest = 1'b0;
      if (i == 1) begin
        cfg_start = 1'b1;
        set_cfg('1, '1, '1, '1, 32'hDEADBEEF);
      end
      if (i == 2) cfg_start = 1'b0;
      check($sformatf("t3_m_addr%0d", i), mgmt_address, 6'h04);
      check($sformatf("t3_m_data%0d", i), mgmt_writedata, 32'hA0A);
      check($sformatf("t3_m_wr%0d", i), mgmt_write, 1);
      tick();
    end
    check("t3_c0_addr", mgmt_address, 6'h05);
    check("t3_c0_data", mgmt_writedata, 32'h20403);
    check("t3_c0_busy", busy, 1);
    tick();
    check("t3_c1_data", mgmt_writedata, 32'h40202);
    tick();
    check("t3_k_addr", mgmt_address, 6'h07);
    check("t3_k_data", mgmt_writedata, 32'h8000);
    tick();
    check("t3_start_addr", mgmt_address, 6'h02);
    check("t3_start_data", mgmt_writedata, 32'h0);
    tick();
    check("t3_rd", mgmt_read, 1);
    check("t3_rd_wr", mgmt_write, 0);
    mgmt_readdata = 32'h1;
    tick();
    mgmt_readdata = 32'h0;
    check("t3_rd_end", mgmt_read, 0);

    // Lock glitching low every 10 cycles, then stable
    for (int i = 0; i < 50; i++) begin
      pll_locked = (i % 10 != 9);
      check("t4_glitch_no_done", done, 0);
      tick();
    end
    pll_locked = 1'b1;
    while (cyc < t0 + 82) begin
      check("t4_no_early_done", done, 0);
      tick();
    end
    check("t4_done", done, 1);
    tick();

    // Start coincides with synced lock loss; then lock never returns
    d0 = cyc;
    pll_locked = 1'b0;
    tick();
    tick();
    set_cfg(18'h00202, 18'h20504, 18'h00303, 18'h10101, 32'hA3D70A3D);
    mgmt_readdata = 32'h1;
    t0 = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t5_start_wins", lock_lost, 0);
    check("t5_busy", busy, 1);
    rst_cnt = 0; pulses = 0; done_cnt = 0; prev_rst = 1'b0;
    while (cyc < t0 + 341) begin
      if (pll_rst) rst_cnt++;
      if (pll_rst && !prev_rst) pulses++;
      if (done) done_cnt++;
      if (cyc == t0 + 108) check("t5_rst_before", pll_rst, 0);
      if (cyc == t0 + 109) check("t5_rst_first", pll_rst, 1);
      prev_rst = pll_rst;
      tick();
    end
    check("t5_lost_stays", lock_lost, 0);
    check("t5_error", error, 1);
    check("t5_busy_end", busy, 0);
    check("t5_rst_cycles", rst_cnt, 32);
    check("t5_rst_pulses", pulses, 2);
    check("t5_no_done", done_cnt, 0);
    tick();
    tick();
    check("t5_error_sticky", error, 1);

    // Reset during POLL, then a fresh complete run
    mgmt_readdata = 32'h0;
    t0 = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t6_error_clr", error, 0);
    check("t6_busy", busy, 1);
    while (cyc < t0 + 10) tick();
    check("t6_polling", mgmt_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("t6_rst");
    tick();
    pll_locked = 1'b1;
    mgmt_readdata = 32'h1;
    repeat (3) tick();
    load_exp1();
    t0 = cyc;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t6_busy2", busy, 1);
    run_writes();
    check("t6_rd", mgmt_read, 1);
    tick();
    while (cyc < t0 + 25) begin
      check("t6_no_early_done", done, 0);
      tick();
    end
    check("t6_done", done, 1);
    check("t6_done_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
